adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Round-robin arbiter that shares one registered valid/data datapath stage among NUM_REQ requesters.
- Each cycle it selects at most one requester, drives the shared stage's din_valid/din, and tracks the owner through a tag pipeline matched to the stage latency.
- It routes each returned dout back to its owner as a one-hot response.
- Sits between the requester clients and the single shared stage instance.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- WIDTH, 8, data width; must match the shared stage WIDTH.
- DP_LAT, 1, shared stage latency in cycles from din_valid to dout_valid; 1..8.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_data  input  NUM_REQ*WIDTH  flat request data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  output  NUM_REQ  one-hot grant/accept
- dp_din_valid  output  1  to shared stage din_valid
- dp_din  output  WIDTH  to shared stage din
- dp_dout_valid  input  1  from shared stage dout_valid
- dp_dout  input  WIDTH  from shared stage dout
- rsp_valid  output  NUM_REQ  one-hot response valid
- rsp_data  output  WIDTH  response data, common to all requesters
- err_sticky  output  1  tag/valid mismatch seen

Interface (already decided): reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Handshake: transfer on req_valid[i] & req_ready[i]. A requester holds req_valid and req_data stable until accepted. No backpressure on responses.
- Grant is combinational from req_valid and the rr pointer ptr, which has clog2(NUM_REQ) bits.
  - Search order is ptr, ptr+1, ... with modulo NUM_REQ wrap. The first asserted requester wins.
  - req_ready is one-hot or zero, never multi-hot.
- dp_din_valid = |req_valid. dp_din = req_data slice of the winner, or 0 when idle. Zero cycles added on the request path.
- ptr update on a grant to index g: ptr <= (g == NUM_REQ-1) ? 0 : g+1. No grant -> ptr holds.
- Tag pipeline: DP_LAT registered stages of {tvld, tidx}.
  - Stage 0 loads {dp_din_valid, winner index}.
  - Last stage aligns with dp_dout_valid.
- Response:
  - rsp_valid[tidx] = tvld_last & dp_dout_valid; all other bits 0.
  - rsp_data = dp_dout, passed through combinationally.
  - Total request-to-response latency is DP_LAT cycles.
- Mismatch: tvld_last != dp_dout_valid -> err_sticky <= 1. It stays set until reset; rsp_valid is suppressed that cycle.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 grants.
- Reset values: ptr = 0, all tag stages tvld = 0 and tidx = 0, err_sticky = 0.
  - Combinational outputs follow: req_ready = 0 and dp_din_valid = 0 while req_valid = 0.
  - rsp_valid = 0 because tvld = 0.
- Reset mid-operation: in-flight tags are discarded. Stale dout_valid from the stage does not occur because the stage resets on the same rst_n.
- Back-to-back: a new grant is allowed every cycle; the tag pipe is fully pipelined.

Optional Feature:
- Macro: ADDER_ARB_STATS_EN.
- Defined: adds output grant_cnt, NUM_REQ*16 bits. One 16-bit counter per requester increments on each accepted transfer, saturates at 16'hFFFF, and resets to 0. Adds input stats_clr, a 1-cycle synchronous clear of all counters; clear wins over a simultaneous increment.
- Undefined: no ports, no counters; behaviour otherwise identical.

Decomposition:
- Package adder_arb_pkg holds:
  - IDX_W = $clog2(NUM_REQ) helper function.
  - Tag struct typedef {vld, idx}.
  - STAT_W = 16 constant.
- Sub-module rr_arbiter: combinational rr search plus ptr register. Ports: req, grant one-hot, grant_idx, any_grant.
- The top holds the data mux, tag pipe, response decode, error flag and stats.

Test Plan:
- Single requester: req 2 sends 0x5A, DP_LAT=1 -> req_ready[2] same cycle, dp_din=0x5A; next cycle rsp_valid=4'b0100, rsp_data=0x5A.
- All 4 requesting continuously from reset -> grant order 0,1,2,3,0,... with one grant per cycle; responses echo the same order 1 cycle later.
- Requests 1 and 3 only, ptr at 2 -> grant 3, then 1, then 3; requesters 0 and 2 never see ready.
- DP_LAT=3, alternate req 0 data 0x11 / req 1 data 0x22 for 6 cycles -> rsp one-hot and data match each issue exactly 3 cycles later; err_sticky = 0.
- Force dp_dout_valid=1 with no outstanding tag -> err_sticky rises next edge and stays set; rsp_valid stays 0; rst_n low clears it.
- Stats build: 5 grants to req 0, then stats_clr pulsed coincident with a grant -> counter reads 5, then 0; driving the counter to 0xFFFF then one more grant -> stays 0xFFFF.

Source files
------------

// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_pkg
// Brief    : Shared types and constants for the adder_share_arb arbiter slice.
// Options  : none here; ADDER_ARB_STATS_EN is consumed by adder_share_arb.
// Revision : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

   // Width of each per-requester grant statistics counter.
   localparam int STAT_W    = 16;

   // Tag index field is sized for the largest supported requester count (16).
   localparam int TAG_IDX_W = 4;

   // One tag-pipeline entry: is a transfer in flight, and who owns it.
   typedef struct packed {
      logic                 vld;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

   // Index width for a requester count (n >= 2).
   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin search starting at a pointer, plus the
//            pointer register that moves just past the most recent winner.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any_grant
);

   logic [IDX_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_idx;
   logic               w_found;

   // First asserted request at or after r_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_grant[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
            w_idx   = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Pointer moves to one past the winner; it holds when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
      end
   end

   assign o_grant     = w_grant;
   assign o_grant_idx = w_idx;
   assign o_any_grant = w_found;

endmodule
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arb
// Brief    : Shares one registered valid/data stage among NUM_REQ requesters.
//            Round-robin grant on the request side, an owner-tag pipeline
//            matched to the stage latency, one-hot routing of the returned
//            data, and a sticky flag for tag/valid disagreement.
// Options  : `define ADDER_ARB_STATS_EN adds i_stats_clr and o_grant_cnt
//            (one saturating 16-bit accept counter per requester).
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arb
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int DP_LAT  = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]       o_req_ready,
   output logic                     o_dp_din_valid,
   output logic [WIDTH-1:0]         o_dp_din,
   input  logic                     i_dp_dout_valid,
   input  logic [WIDTH-1:0]         i_dp_dout,
   output logic [NUM_REQ-1:0]       o_rsp_valid,
   output logic [WIDTH-1:0]         o_rsp_data,
   output logic                     o_err_sticky
`ifdef ADDER_ARB_STATS_EN
   ,
   input  logic                     i_stats_clr,
   output logic [NUM_REQ*STAT_W-1:0] o_grant_cnt
`endif
);

   localparam int IDX_W = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_any_grant;
   logic [WIDTH-1:0]   w_din;
   tag_t               w_tag_in;
   tag_t               r_tag [DP_LAT];
   tag_t               w_tag_last;
   logic               w_mismatch;
   logic               r_err;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (i_req_valid),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any_grant (w_any_grant)
   );

   // Winner's data slice onto the shared stage; zero when idle.
   always_comb begin
      w_din = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_din = i_req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Any request is always granted, so stage valid equals "some grant".
   assign o_req_ready    = w_grant;
   assign o_dp_din_valid = w_any_grant;
   assign o_dp_din       = w_din;

   assign w_tag_in.vld = w_any_grant;
   assign w_tag_in.idx = TAG_IDX_W'(w_grant_idx);

   // First tag stage captures the owner of this cycle's issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag[0] <= '0;
      end else begin
         r_tag[0] <= w_tag_in;
      end
   end

   generate
      for (genvar s = 1; s < DP_LAT; s++) begin : g_tag_stage
         // Remaining tag stages shift in lockstep with the shared stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tag[s] <= '0;
            end else begin
               r_tag[s] <= r_tag[s-1];
            end
         end
      end
   endgenerate

   assign w_tag_last = r_tag[DP_LAT-1];
   assign w_mismatch = (w_tag_last.vld != i_dp_dout_valid);

   // Route returned data to its owner; requiring both valids also drops
   // the response in any cycle where tag and stage disagree.
   always_comb begin
      o_rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_tag_last.idx == TAG_IDX_W'(i)) begin
            o_rsp_valid[i] = w_tag_last.vld & i_dp_dout_valid;
         end
      end
   end

   assign o_rsp_data = i_dp_dout;

   // Sticky record of any tag/valid disagreement; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_mismatch) begin
         r_err <= 1'b1;
      end
   end

   assign o_err_sticky = r_err;

`ifdef ADDER_ARB_STATS_EN
   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats_cnt
         logic [STAT_W-1:0] r_cnt;

         // Saturating accept counter; clear takes priority over increment.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (i_stats_clr) begin
               r_cnt <= '0;
            end else if (w_grant[i] && (r_cnt != {STAT_W{1'b1}})) begin
               r_cnt <= r_cnt + STAT_W'(1);
            end
         end

         assign o_grant_cnt[i*STAT_W +: STAT_W] = r_cnt;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_adder_share_arb
// Brief    : Randomized scoreboard bench for adder_share_arb with a modelled
//            shared stage of latency LAT. Define ADDER_ARB_STATS_EN to also
//            exercise the grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_share_arb;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           din_valid;
   logic [W-1:0]   din;
   logic           dout_valid;
   logic [W-1:0]   dout;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           err_sticky;
   logic           force_dv = 1'b0;
   logic           stats_clr = 1'b0;
`ifdef ADDER_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   always #5 clk = ~clk;

   adder_share_arb #(.NUM_REQ(N), .WIDTH(W), .DP_LAT(LAT)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_req_valid     (req_valid),
      .i_req_data      (req_data),
      .o_req_ready     (req_ready),
      .o_dp_din_valid  (din_valid),
      .o_dp_din        (din),
      .i_dp_dout_valid (dout_valid),
      .i_dp_dout       (dout),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_data      (rsp_data),
      .o_err_sticky    (err_sticky)
`ifdef ADDER_ARB_STATS_EN
      ,
      .i_stats_clr     (stats_clr),
      .o_grant_cnt     (grant_cnt)
`endif
   );

   // Shared stage model: plain LAT-deep valid/data delay line.
   logic [LAT-1:0] s_v;
   logic [W-1:0]   s_d [LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_v <= '0;
         for (int i = 0; i < LAT; i++) s_d[i] <= '0;
      end else begin
         s_v <= {s_v[LAT-2:0], din_valid};
         s_d[0] <= din;
         for (int i = 1; i < LAT; i++) s_d[i] <= s_d[i-1];
      end
   end
   assign dout_valid = s_v[LAT-1] | force_dv;
   assign dout       = s_d[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         idx;
      logic [W-1:0] data;
      int         due;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int last_g   = N - 1;
   int mcnt [N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference arbitration: scan onward from the last winner.
   function automatic int pick(input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last_g + k) % N]) return (last_g + k) % N;
      end
      return -1;
   endfunction

   // Response monitor: every presented response must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (rsp_valid != '0)) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got rsp_valid %0h expected none", rsp_valid);
         end else begin
            e = sb.pop_front();
            check("rsp_onehot", 64'(rsp_valid), 64'(1) << e.idx);
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   // One cycle: check request-side outputs, predict response, advance clock.
   task automatic step();
      int g;
      logic [W-1:0] d;
      #1;
      g = pick(req_valid);
      d = (g >= 0) ? req_data[g*W +: W] : '0;
      check("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
      check("din_valid", 64'(din_valid), 64'(|req_valid));
      check("din", 64'(din), 64'(d));
      if (g >= 0) begin
         sb.push_back('{g, d, cyc + LAT});
         last_g = g;
      end
      if (stats_clr) begin
         for (int i = 0; i < N; i++) mcnt[i] = 0;
      end else if (g >= 0 && mcnt[g] < 65535) begin
         mcnt[g]++;
      end
      @(posedge clk);
      #1;
      if (g >= 0) req_valid[g] = 1'b0;
   endtask

   // Raise requests in mask that are not already pending, with fresh data.
   task automatic refill(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (mask[i] && !req_valid[i]) begin
            req_valid[i] = 1'b1;
            req_data[i*W +: W] = W'($urandom);
         end
      end
   endtask

   task automatic drain();
      req_valid = '0;
      repeat (LAT + 2) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      force_dv = 1'b0;
      stats_clr = 1'b0;
      repeat (2) @(posedge clk);
      sb.delete();
      last_g = N - 1;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      #1;
      check("reset_ready", 64'(req_ready), 64'(0));
      check("reset_din_valid", 64'(din_valid), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_err", 64'(err_sticky), 64'(0));

      // Single requester 2 sends 0x5A.
      req_valid = 4'b0100;
      req_data[2*W +: W] = 8'h5A;
      step();
      drain();

      // All four requesting continuously from reset.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         refill(4'b1111);
         step();
      end
      drain();

      // Move pointer to 2 via requester 1, then 1 and 3 compete.
      req_valid = 4'b0010;
      req_data[1*W +: W] = 8'h10;
      step();
      for (int c = 0; c < 6; c++) begin
         refill(4'b1010);
         step();
      end
      drain();

      // Alternate requester 0 (0x11) and requester 1 (0x22).
      for (int c = 0; c < 6; c++) begin
         req_valid = '0;
         if (c % 2 == 0) begin
            req_valid[0] = 1'b1;
            req_data[0 +: W] = 8'h11;
         end else begin
            req_valid[1] = 1'b1;
            req_data[W +: W] = 8'h22;
         end
         step();
      end
      drain();
      check("alt_err", 64'(err_sticky), 64'(0));

      // Random traffic, requesters hold until accepted.
      for (int c = 0; c < 400; c++) begin
         refill(N'($urandom));
         step();
      end
      drain();
      check("sb_drained", 64'(sb.size()), 64'(0));
      check("rand_err", 64'(err_sticky), 64'(0));

      // Stage valid with no tag outstanding.
      force_dv = 1'b1;
      #1;
      check("mis_rsp_valid", 64'(rsp_valid), 64'(0));
      check("mis_err_before", 64'(err_sticky), 64'(0));
      @(posedge clk);
      #1;
      check("mis_err_set", 64'(err_sticky), 64'(1));
      force_dv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mis_err_hold", 64'(err_sticky), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mis_err_rst", 64'(err_sticky), 64'(0));
      do_reset();

`ifdef ADDER_ARB_STATS_EN
      for (int c = 0; c < 5; c++) begin
         refill(4'b0001);
         step();
      end
      check("cnt_five", 64'(grant_cnt[15:0]), 64'(mcnt[0]));
      check("cnt_five_abs", 64'(grant_cnt[15:0]), 64'(5));
      refill(4'b0001);
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      check("cnt_clr", 64'(grant_cnt[15:0]), 64'(0));
      for (int c = 0; c < 65536; c++) begin
         refill(4'b0001);
         step();
      end
      for (int i = 0; i < N; i++)
         check("cnt_sat", 64'(grant_cnt[i*16 +: 16]), 64'(mcnt[i]));
      check("cnt_sat_abs", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
      drain();
`endif

      check("final_drained", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
